// File: rtl/proc_pkg.sv
// proc_pkg: constants shared by the processor's memory-mapped peripherals.
//   IO_TX_ADDR      - data-memory address whose stores go to the serial port.
//   tx_state_t      - transmit FSM encoding (IDLE=0, START=1, DATA=2,
//                     STOP=3, PARITY=4).
//   UART_IDLE_LEVEL - level of the serial line between frames.
package proc_pkg;

   localparam logic [7:0] IO_TX_ADDR      = 8'hFF;
   localparam logic       UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head read.
//   clk, rst_n  - clock, synchronous active-low reset (pointers/count only).
//   push, wdata - write request and data; dropped when full unless the
//                 same cycle also pops.
//   pop, rdata  - remove the head; rdata always shows the current head.
//   full, empty - occupancy flags.
//   count       - number of stored entries, 0..DEPTH.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // When full, a simultaneous pop frees the slot the push writes into
   // (wr_ptr == rd_ptr); the head is read before the edge overwrites it.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count define validity,
   // and leaving it out keeps the array mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped serial output port on the processor store bus.
//   clk, rst_n  - clock, synchronous active-low reset.
//   mem_addr    - data-memory address; stores to IO_ADDR are captured.
//   mem_data    - store data.
//   memWE       - memory write enable.
//   ovf_clr     - clears the sticky overflow flag (a new drop wins).
//   tx          - registered serial line, idles high, 8N1 frames LSB first.
//   busy        - high while a frame is in flight.
//   fifo_count  - number of queued bytes.
//   overflow    - sticky: a store was dropped because the queue was full.
// Build option: define MMIO_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame = 11 bit times).
module mmio_uart_tx
   import proc_pkg::*;
#(
   parameter logic [7:0] IO_ADDR      = IO_TX_ADDR,
   parameter int         DEPTH        = 4,
   parameter int         CLKS_PER_BIT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             mem_addr,
   input  logic [7:0]             mem_data,
   input  logic                   memWE,
   input  logic                   ovf_clr,
   output logic                   tx,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow
);

   localparam int BW = $clog2(CLKS_PER_BIT);

   tx_state_t     state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    head;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic          baud_last;
`ifdef MMIO_UART_TX_PARITY_EN
   logic          parity;
`endif

   assign push      = memWE && (mem_addr == IO_ADDR);
   assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
   // The FSM takes the head when idle, or on the last stop cycle so the next
   // start bit follows with no idle gap.
   assign pop = !fifo_empty &&
                ((state == ST_IDLE) || ((state == ST_STOP) && baud_last));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (mem_data),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A drop is a push into a full queue that is not popping this cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)                           overflow <= 1'b0;
      else if (push && fifo_full && !pop)   overflow <= 1'b1;
      else if (ovf_clr)                     overflow <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= UART_IDLE_LEVEL;
         busy    <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shift <= head;
`ifdef MMIO_UART_TX_PARITY_EN
                  parity <= ^head;
`endif
                  baud  <= '0;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_START;
               end
            end

            ST_START: begin
               if (baud_last) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= ST_DATA;
               end else begin
                  baud <= baud + BW'(1);
               end
            end

            // shift[0] is always the bit on the line; the next bit is shift[1].
            ST_DATA: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                     tx    <= parity;
                     state <= ST_PARITY;
`else
                     tx    <= UART_IDLE_LEVEL;
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end

`ifdef MMIO_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_last) begin
                  baud  <= '0;
                  tx    <= UART_IDLE_LEVEL;
                  state <= ST_STOP;
               end else begin
                  baud <= baud + BW'(1);
               end
            end
`endif

            ST_STOP: begin
               if (baud_last) begin
                  baud <= '0;
                  if (pop) begin
                     shift <= head;
`ifdef MMIO_UART_TX_PARITY_EN
                     parity <= ^head;
`endif
                     tx    <= 1'b0;
                     state <= ST_START;
                  end else begin
                     tx    <= UART_IDLE_LEVEL;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
               baud  <= '0;
               tx    <= UART_IDLE_LEVEL;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx (DEPTH=4, CLKS_PER_BIT=4).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_mmio_uart_tx;

   localparam int CPB = 4;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FL = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] mem_addr;
   logic [7:0] mem_data;
   logic       memWE;
   logic       ovf_clr;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   int vectors = 0;
   int errors  = 0;
   logic [7:0] exp_bytes [8];

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .IO_ADDR      (8'hFF),
      .DEPTH        (4),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .memWE      (memWE),
      .ovf_clr    (ovf_clr),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (time %0t, required end before 2ms)", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [7:0] addr, input logic [7:0] data);
      memWE    = 1'b1;
      mem_addr = addr;
      mem_data = data;
      step();
      memWE    = 1'b0;
   endtask

   // Expected line level for frame bit b (0 = start, last = stop).
   function automatic logic frame_bit(input logic [7:0] d, input int b);
      if (b == 0)             return 1'b0;
      if (b >= 1 && b <= 8)   return d[b-1];
`ifdef MMIO_UART_TX_PARITY_EN
      if (b == 9)             return ^d;
`endif
      return 1'b1;
   endfunction

   // Checks tx/busy on every cycle of n contiguous frames, starting t cycles
   // after the edge where the first start bit began; then checks idle.
   task automatic check_stream(input int n, input int t0, input string name);
      for (int t = t0; t < n * FL; t++) begin
         logic exp_tx;
         exp_tx = frame_bit(exp_bytes[t / FL], (t % FL) / CPB);
         vectors++;
         if (tx !== exp_tx || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s t=%0d: tx=%b busy=%b, required tx=%b busy=1", name, t, tx, busy, exp_tx);
         end
         step();
      end
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL %s end: tx=%b busy=%b count=%0d, required 1 0 0", name, tx, busy, fifo_count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; memWE = 1'b0; mem_addr = '0; mem_data = '0; ovf_clr = 1'b0;
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle c=%0d: tx=%b busy=%b count=%0d ovf=%b, required 1 0 0 0", i, tx, busy, fifo_count, overflow);
         end
         step();
      end
   endtask

   task automatic test_single();
      store(8'hFF, 8'h41);
      vectors++;
      if (fifo_count !== 3'd1 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_capture: count=%0d tx=%b, required 1 1", fifo_count, tx);
      end
      step();
      vectors++;
      if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL single_start: tx=%b busy=%b count=%0d, required 0 1 0", tx, busy, fifo_count);
      end
      for (int k = 0; k < NBITS; k++) begin
         logic exp_tx;
         exp_tx = frame_bit(8'h41, k);
         step(); step();
         vectors++;
         if (tx !== exp_tx) begin
            errors++;
            $display("FAIL single_bit%0d: tx=%b, required %b", k, tx, exp_tx);
         end
         step(); step();
      end
      vectors++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_done: busy=%b tx=%b, required 0 1", busy, tx);
      end
   endtask

   task automatic test_other_addr();
      store(8'h10, 8'h55);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (fifo_count !== 3'd0 || tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL other_addr c=%0d: count=%0d tx=%b busy=%b, required 0 1 0", i, fifo_count, tx, busy);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) store(8'hFF, 8'(i + 1));
      // 01 started on the second write edge, so the bench is now 4 cycles in.
      vectors++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL b2b_fill: count=%0d ovf=%b, required 4 1", fifo_count, overflow);
      end
      for (int i = 0; i < 5; i++) exp_bytes[i] = 8'(i + 1);
      check_stream(5, 4, "b2b_stream");
      vectors++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%b, required 1", overflow);
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      vectors++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
      end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      store(8'hFF, 8'hA5);
      step();                          // start bit begins (offset 0)
      repeat (17) step();              // offset 17: inside data bit 3
      vectors++;
      if (tx !== frame_bit(8'hA5, 4) || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: tx=%b busy=%b, required %b 1", tx, busy, frame_bit(8'hA5, 4));
      end
      rst_n = 1'b0;
      step();
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL rst_mid_edge: tx=%b busy=%b count=%0d, required 1 0 0", tx, busy, fifo_count);
      end
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_mid_residual: %0d active cycles after release, required 0", bad);
      end
   endtask

`ifdef MMIO_UART_TX_PARITY_EN
   task automatic test_parity();
      store(8'hFF, 8'h07);
      step();
      exp_bytes[0] = 8'h07;
      check_stream(1, 0, "parity_frame");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_other_addr();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef MMIO_UART_TX_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
